// File: rtl/complex_mixer_pkg.sv
// complex_mixer_pkg: shared types for the complex mixer slice
package complex_mixer_pkg;
  typedef enum logic {REAL = 1'b0, COMPLEX = 1'b1} mixer_mode_e;
endpackage

// File: rtl/complex_mixer_if.sv
// complex_mixer_if: sample/NCO inputs and mixed outputs of the complex mixer
interface complex_mixer_if #(
  parameter int IN_W  = 18,
  parameter int NCO_W = 18,
  parameter int OUT_W = 18,
  parameter int CH_W  = 2
) ();
  logic             ipMode;
  logic             ipConj;
  logic             ipValid;
  logic [CH_W-1:0]  ipChannel;
  logic [IN_W-1:0]  ipI;
  logic [IN_W-1:0]  ipQ;
  logic [NCO_W-1:0] ipNcoI;
  logic [NCO_W-1:0] ipNcoQ;
  logic             ipClearOverflow;
  logic             opValid;
  logic [CH_W-1:0]  opChannel;
  logic [OUT_W-1:0] opI;
  logic [OUT_W-1:0] opQ;
  logic             opOverflow;
  modport master (
    output ipMode, ipConj, ipValid, ipChannel, ipI, ipQ, ipNcoI, ipNcoQ, ipClearOverflow,
    input  opValid, opChannel, opI, opQ, opOverflow
  );
  modport slave (
    input  ipMode, ipConj, ipValid, ipChannel, ipI, ipQ, ipNcoI, ipNcoQ, ipClearOverflow,
    output opValid, opChannel, opI, opQ, opOverflow
  );
endinterface

// File: rtl/complex_mixer_round_saturate.sv
// round_saturate: optional half-up rounding, arithmetic right shift, signed saturation
module round_saturate #(
  parameter int IN_W  = 37,
  parameter int SHIFT = 17,
  parameter int OUT_W = 18,
  parameter int ROUND = 1
) (
  input  logic signed [IN_W-1:0] d_i,
  output logic [OUT_W-1:0]       q_o,
  output logic                   sat_o
);
  localparam logic signed [IN_W:0] BIAS = (ROUND != 0) ? ({{IN_W{1'b0}}, 1'b1} << (SHIFT - 1)) : '0;
  localparam logic signed [IN_W:0] MAXV = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = ~MAXV;
  logic signed [IN_W:0] r, s;
  logic hi, lo;
  always_comb begin
    r     = {d_i[IN_W-1], d_i} + BIAS;
    s     = r >>> SHIFT;
    hi    = s > MAXV;
    lo    = s < MINV;
    q_o   = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : s[OUT_W-1:0];
    sat_o = hi | lo;
  end
endmodule

// File: rtl/complex_mixer.sv
// complex_mixer: 3-stage complex x NCO multiply with round/saturate and sticky overflow
module complex_mixer
  import complex_mixer_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int NCO_W = 18,
  parameter int OUT_W = 18,
  parameter int CH_W  = 2,
  parameter int ROUND = 1
) (
  input logic           ipClk,
  input logic           ipnReset,
  complex_mixer_if.slave bus
);
  localparam int PW = IN_W + NCO_W;
  logic signed [IN_W-1:0]  xi, xq;
  logic signed [NCO_W-1:0] ni, nq;
  logic signed [PW-1:0]    pii_d, pqq_d, piq_d, pqi_d, pii_q, pqq_q, piq_q, pqi_q;
  logic signed [PW:0]      si_d, sq_d, si_q, sq_q;
  logic [OUT_W-1:0]        oi_d, oq_d, oi_q, oq_q;
  logic [CH_W-1:0]         ch1_q, ch2_q, ch3_q;
  logic                    v1_q, v2_q, v3_q, cj1_q, ov_d, ov_q, sat_i, sat_q;
  always_comb begin
    xi    = bus.ipI;
    xq    = (mixer_mode_e'(bus.ipMode) == COMPLEX) ? bus.ipQ : '0;
    ni    = bus.ipNcoI;
    nq    = bus.ipNcoQ;
    pii_d = PW'(xi) * PW'(ni);
    pqq_d = PW'(xq) * PW'(nq);
    piq_d = PW'(xi) * PW'(nq);
    pqi_d = PW'(xq) * PW'(ni);
    si_d  = cj1_q ? (PW+1)'(pii_q) + (PW+1)'(pqq_q) : (PW+1)'(pii_q) - (PW+1)'(pqq_q);
    sq_d  = cj1_q ? (PW+1)'(pqi_q) - (PW+1)'(piq_q) : (PW+1)'(piq_q) + (PW+1)'(pqi_q);
    // a saturating sample arriving together with a clear keeps the flag set
    ov_d  = (v2_q & (sat_i | sat_q)) | (ov_q & ~bus.ipClearOverflow);
  end
  round_saturate #(.IN_W(PW + 1), .SHIFT(NCO_W - 1), .OUT_W(OUT_W), .ROUND(ROUND)) u_rs_i (
    .d_i(si_q), .q_o(oi_d), .sat_o(sat_i)
  );
  round_saturate #(.IN_W(PW + 1), .SHIFT(NCO_W - 1), .OUT_W(OUT_W), .ROUND(ROUND)) u_rs_q (
    .d_i(sq_q), .q_o(oq_d), .sat_o(sat_q)
  );
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      {v1_q, v2_q, v3_q, cj1_q, ov_q} <= '0;
      {ch1_q, ch2_q, ch3_q} <= '0;
      {pii_q, pqq_q, piq_q, pqi_q} <= '0;
      {si_q, sq_q} <= '0;
      {oi_q, oq_q} <= '0;
    end else begin
      v1_q <= bus.ipValid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      ov_q <= ov_d;
      if (bus.ipValid) begin
        {pii_q, pqq_q, piq_q, pqi_q} <= {pii_d, pqq_d, piq_d, pqi_d};
        ch1_q <= bus.ipChannel;
        cj1_q <= bus.ipConj;
      end
      if (v1_q) begin
        {si_q, sq_q} <= {si_d, sq_d};
        ch2_q <= ch1_q;
      end
      if (v2_q) begin
        {oi_q, oq_q} <= {oi_d, oq_d};
        ch3_q <= ch2_q;
      end
    end
  end
  assign bus.opValid    = v3_q;
  assign bus.opChannel  = ch3_q;
  assign bus.opI        = oi_q;
  assign bus.opQ        = oq_q;
  assign bus.opOverflow = ov_q;
endmodule

// File: tb/tb_complex_mixer.sv
// tb_complex_mixer: directed + streaming check of complex_mixer against a queue-based model
module tb_complex_mixer;
  logic ipClk, ipnReset;
  int   n_cmp = 0, n_bad = 0;
  complex_mixer_if #(.IN_W(18), .NCO_W(18), .OUT_W(18), .CH_W(2)) bus ();
  complex_mixer #(.IN_W(18), .NCO_W(18), .OUT_W(18), .CH_W(2), .ROUND(1)) dut (
    .ipClk(ipClk), .ipnReset(ipnReset), .bus(bus)
  );
  initial begin
    ipClk = 0;
    forever #5 ipClk = ~ipClk;
  end

  typedef struct {int due; longint i; longint q; int ch; bit sat;} exp_t;
  exp_t   eq[$];
  logic   ev, eov;
  longint ei, eqv;
  int     ech;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  function automatic longint rsat(input longint p, inout bit sat);
    longint v;
    v = (p + 65536) >>> 17;
    if (v > 131071) begin sat = 1; v = 131071; end
    else if (v < -131072) begin sat = 1; v = -131072; end
    return v;
  endfunction

  // complex product x * n (or x * conj(n)), scaled by 2^-17
  function automatic void mix(input longint xr, xim, nr, nim, input bit conj,
                              output longint oi, output longint oq, output bit sat);
    longint m;
    m   = conj ? -nim : nim;
    sat = 0;
    oi  = rsat(xr * nr - xim * m, sat);
    oq  = rsat(xr * m + xim * nr, sat);
  endfunction

  initial begin
    int     cyc = 0;
    exp_t   r;
    longint oi, oq;
    bit     s;
    ev = 0; ei = 0; eqv = 0; ech = 0; eov = 0;
    forever begin
      @(posedge ipClk or negedge ipnReset);
      if (!ipnReset) begin
        eq.delete();
        ev = 0; ei = 0; eqv = 0; ech = 0; eov = 0;
      end else begin
        cyc++;
        ev = 0;
        if (eq.size() > 0 && eq[0].due == cyc) begin
          r = eq.pop_front();
          ev = 1; ei = r.i; eqv = r.q; ech = r.ch;
        end
        if (ev && r.sat) eov = 1;
        else if (bus.ipClearOverflow) eov = 0;
        if (bus.ipValid) begin
          mix($signed(bus.ipI), bus.ipMode ? longint'($signed(bus.ipQ)) : 0,
              $signed(bus.ipNcoI), $signed(bus.ipNcoQ), bus.ipConj, oi, oq, s);
          eq.push_back('{cyc + 2, oi, oq, int'(bus.ipChannel), s});
        end
      end
    end
  end

  initial forever begin
    @(negedge ipClk);
    chk("opValid", bus.opValid, ev);
    chk("opI", $signed(bus.opI), ei);
    chk("opQ", $signed(bus.opQ), eqv);
    chk("opChannel", bus.opChannel, ech);
    chk("opOverflow", bus.opOverflow, eov);
  end

  task automatic drv(input bit v, m, c, input logic [1:0] ch, input logic [17:0] xi, xq, ni, nq,
                     input bit clr);
    @(posedge ipClk);
    #1;
    bus.ipValid = v; bus.ipMode = m; bus.ipConj = c; bus.ipChannel = ch;
    bus.ipI = xi; bus.ipQ = xq; bus.ipNcoI = ni; bus.ipNcoQ = nq; bus.ipClearOverflow = clr;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  localparam logic [17:0] ONE = 18'd131071;
  localparam logic [17:0] NEG = 18'h20000;

  initial begin
    longint oi, oq;
    bit     s;
    ipnReset = 0;
    bus.ipValid = 0; bus.ipMode = 0; bus.ipConj = 0; bus.ipChannel = 0;
    bus.ipI = 0; bus.ipQ = 0; bus.ipNcoI = 0; bus.ipNcoQ = 0; bus.ipClearOverflow = 0;
    mix(1000, 0, 131071, 0, 0, oi, oq, s);
    chk("model_real_i", oi, 1000);
    mix(1000, 0, 0, 131071, 1, oi, oq, s);
    chk("model_conj_q", oq, -1000);
    mix(-131072, -131072, -131072, 0, 0, oi, oq, s);
    chk("model_sat_i", oi, 131071);
    chk("model_sat_flag", longint'(s), 1);
    repeat (2) @(posedge ipClk);
    #1;
    chk("rst_valid", bus.opValid, 0);
    chk("rst_i", $signed(bus.opI), 0);
    chk("rst_ovf", bus.opOverflow, 0);
    #2 ipnReset = 1;

    drv(1, 0, 0, 2'd2, 18'd1000, 18'd777, ONE, 18'd0, 0);
    idle(); idle(); idle();
    chk("t1_valid", bus.opValid, 1);
    chk("t1_i", $signed(bus.opI), 1000);
    chk("t1_q", $signed(bus.opQ), 0);
    chk("t1_ch", bus.opChannel, 2);
    idle();
    chk("t1_pulse", bus.opValid, 0);

    drv(1, 1, 0, 2'd1, 18'd1000, 18'd0, 18'd0, ONE, 0);
    drv(1, 1, 1, 2'd3, 18'd1000, 18'd0, 18'd0, ONE, 0);
    idle(); idle();
    chk("t2_c0_i", $signed(bus.opI), 0);
    chk("t2_c0_q", $signed(bus.opQ), 1000);
    idle();
    chk("t2_c1_q", $signed(bus.opQ), -1000);
    chk("t2_c1_ch", bus.opChannel, 3);

    drv(1, 1, 0, 2'd0, NEG, NEG, NEG, 18'd0, 0);
    idle(); idle(); idle();
    chk("t3_i", $signed(bus.opI), 131071);
    chk("t3_q", $signed(bus.opQ), 131071);
    chk("t3_ovf", bus.opOverflow, 1);
    idle(); idle(); idle();
    chk("t3_hold", bus.opOverflow, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("t3_clear", bus.opOverflow, 0);
    drv(1, 1, 0, 2'd0, NEG, NEG, NEG, 18'd0, 0);
    idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("t3_setwins", bus.opOverflow, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("t3_clear2", bus.opOverflow, 0);

    for (int i = 0; i < 64; i++)
      drv(1, i[0], i[1], 2'(i), 18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom), 0);
    repeat (4) idle();

    drv(1, 0, 0, 2'd1, 18'd1000, 18'd0, ONE, 18'd0, 0);
    drv(1, 0, 0, 2'd2, 18'd2000, 18'd0, ONE, 18'd0, 0);
    drv(1, 0, 0, 2'd3, 18'd3000, 18'd0, ONE, 18'd0, 0);
    #2;
    ipnReset = 0;
    bus.ipValid = 0;
    #1;
    chk("t5_valid", bus.opValid, 0);
    chk("t5_i", $signed(bus.opI), 0);
    chk("t5_ch", bus.opChannel, 0);
    repeat (2) @(posedge ipClk);
    #3 ipnReset = 1;
    repeat (6) idle();

    drv(1, 0, 0, 2'd1, 18'd1000, 18'd0, ONE, 18'd0, 0);
    idle(); idle();
    drv(1, 0, 0, 2'd2, 18'd2000, 18'd0, ONE, 18'd0, 0);
    chk("t6_a", $signed(bus.opI), 1000);
    idle();
    chk("t6_hold_i", $signed(bus.opI), 1000);
    chk("t6_hold_v", bus.opValid, 0);
    idle();
    chk("t6_hold_ch", bus.opChannel, 1);
    idle();
    chk("t6_b", $signed(bus.opI), 2000);
    repeat (3) idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
